ps2_host_transmitter: RTL and testbench
=======================================

PS2_HOST_TRANSMITTER -- requirements
Module: ps2_host_transmitter

Interface
REQ-001 SHALL have parameter INHIBIT_CYCLES, default 5000, giving clock-inhibit length in Clock cycles (100 us at 50 MHz).
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 1000000, giving the abort limit measured from clock release (20 ms at 50 MHz).
REQ-003 SHALL have parameter FILTER_LEN, default 8, giving the number of identical consecutive samples needed to change a filtered line.
REQ-004 Ports, one clock; reset is asynchronous and active-high:
  Clock         input   1  system clock, rising edge
  Reset         input   1  asynchronous, active-high reset
  iData         input   8  command byte to send
  iSend         input   1  start request, sampled while idle
  PS2_CLK_IN    input   1  raw PS/2 clock pad value
  PS2_DATA_IN   input   1  raw PS/2 data pad value
  oPS2_CLK_OE   output  1  1 = drive PS/2 clock low; 0 = release
  oPS2_DATA_OE  output  1  1 = drive PS/2 data low; 0 = release
  oBusy         output  1  transfer in progress; PS/2 receiver must ignore the bus while high
  oDone         output  1  one-cycle pulse: byte sent and ACK received
  oError        output  1  one-cycle pulse: missing ACK or timeout

Function
REQ-005 Each raw PS/2 line SHALL pass through a 2-FF synchronizer and then a FILTER_LEN-sample filter; the filtered value SHALL change only after FILTER_LEN equal samples.
REQ-006 FSM states SHALL be IDLE, INHIBIT, START, TX, ACK_WAIT, RELEASE_WAIT.
REQ-007 In IDLE, iSend=1 SHALL latch iData and compute odd parity as the XNOR-reduction of iData, go to INHIBIT, and assert oBusy on the next cycle.
REQ-008 iSend SHALL be ignored whenever the FSM is not in IDLE; no queuing.
REQ-009 INHIBIT SHALL hold CLK_OE=1 and DATA_OE=0 for exactly INHIBIT_CYCLES cycles, then go to START.
REQ-010 START SHALL hold CLK_OE=1 and DATA_OE=1 for one cycle, then go to TX with CLK_OE=0 and DATA_OE=1 (start bit).
REQ-011 In TX, a 4-bit edge counter SHALL increment on each filtered-clock falling edge: edges 1-8 set DATA_OE=~data[edge-1] (LSB first), edge 9 sets DATA_OE=~parity, and edge 10 sets DATA_OE=0 (stop bit).
REQ-012 In TX, edge 11 SHALL sample filtered data: 0 goes to RELEASE_WAIT; 1 pulses oError and returns to IDLE.
REQ-013 RELEASE_WAIT SHALL wait until both filtered lines are 1, then pulse oDone and return to IDLE.
REQ-014 A timeout counter SHALL start at entry to TX; on reaching TIMEOUT_CYCLES in TX or RELEASE_WAIT, both OEs SHALL drop to 0, oError SHALL pulse, and the FSM SHALL return to IDLE.
REQ-015 oDone and oError SHALL never be high in the same cycle; oBusy SHALL fall in the same cycle as either pulse.
REQ-016 In IDLE both OEs SHALL be 0; the block SHALL never drive a line high.
REQ-017 The edge counter SHALL saturate at 11; falling edges after ACK sampling SHALL be ignored.

Reset
REQ-018 Reset SHALL asynchronously force IDLE with oPS2_CLK_OE=0, oPS2_DATA_OE=0, oBusy=0, oDone=0, oError=0, counters=0, and filters to 1 (idle bus).
REQ-019 Reset asserted mid-transfer SHALL release both lines immediately, without waiting for a clock edge, and SHALL produce no oDone or oError pulse.

Structure
REQ-020 State encodings and the INHIBIT/TIMEOUT defaults SHALL live in the shared definitions include file alongside the opcode defines.
REQ-021 The synchronizer-plus-filter SHALL be a sub-module ps2_line_filter (parameter FILTER_LEN), instantiated once per line.
REQ-022 Top-level tristate pads SHALL be built from the OE outputs outside this block.

Verification
REQ-023 iData=0xED with the device model clocking and ACKing: data bits observed at the device rising edges are 1,0,1,1,0,1,1,1, then parity 1 and stop 1; oDone pulses once.
REQ-024 iData=0xF4: parity bit 0, oDone pulses, oError stays 0; CLK_OE high for exactly 5000 cycles before START.
REQ-025 Device model leaves data high at edge 11 (iData=0xFF): oError pulses once, oDone stays 0, both OEs are 0 afterwards.
REQ-026 Device model never clocks: oError pulses exactly 1000000 cycles after TX entry and both lines are released.
REQ-027 Reset asserted at edge 5 of a 0x01 transfer: OEs go to 0 combinationally, no pulses; a new iSend of 0xFF then completes normally.
REQ-028 iSend held high for the whole transfer of 0x01: exactly one transfer and one oDone occur; a 1-cycle glitch on PS2_CLK_IN produces no edge count.

Source files
------------

// File: rtl/ps2_host_transmitter_pkg.sv
// Shared definitions for the PS/2 host transmitter: FSM states, timing defaults,
// frame edge numbers, common keyboard command bytes and the parity helper.
package ps2_host_transmitter_pkg;

  localparam int DEFAULT_INHIBIT_CYCLES = 5000;
  localparam int DEFAULT_TIMEOUT_CYCLES = 1000000;
  localparam int DEFAULT_FILTER_LEN     = 8;

  localparam logic [7:0] CMD_SET_LEDS = 8'hED;
  localparam logic [7:0] CMD_ECHO     = 8'hEE;
  localparam logic [7:0] CMD_ENABLE   = 8'hF4;
  localparam logic [7:0] CMD_RESET    = 8'hFF;

  // Device clock falling-edge numbers within one host-to-device frame
  localparam logic [3:0] LAST_DATA_EDGE = 4'd8;
  localparam logic [3:0] PARITY_EDGE    = 4'd9;
  localparam logic [3:0] STOP_EDGE      = 4'd10;
  localparam logic [3:0] ACK_EDGE       = 4'd11;

  typedef enum logic [2:0] {
    IDLE,
    INHIBIT,
    START,
    TX,
    ACK_WAIT,
    RELEASE_WAIT
  } state_t;

  function automatic logic odd_parity(input logic [7:0] d);
    return ~^d;
  endfunction

endpackage

// File: rtl/ps2_line_filter.sv
// Two-flop synchronizer followed by a run-length filter: the filtered output only
// changes once FILTER_LEN consecutive synchronized samples agree.
module ps2_line_filter #(
  parameter int FILTER_LEN = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic line_raw,
  output logic line_filt
);

  logic [1:0]            sync_q, sync_d;
  logic [FILTER_LEN-1:0] hist_q, hist_d;
  logic                  filt_q, filt_d;

  // Everything resets to the idle-bus level so no false edge appears after reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= 2'b11;
      hist_q <= '1;
      filt_q <= 1'b1;
    end else begin
      sync_q <= sync_d;
      hist_q <= hist_d;
      filt_q <= filt_d;
    end
  end

  always_comb begin
    sync_d = {sync_q[0], line_raw};
    hist_d = {hist_q[FILTER_LEN-2:0], sync_q[1]};
    filt_d = filt_q;
    if (&hist_d) begin
      filt_d = 1'b1;
    end else if (~|hist_d) begin
      filt_d = 1'b0;
    end
  end

  assign line_filt = filt_q;

endmodule

// File: rtl/ps2_host_transmitter.sv
// PS/2 host-to-device command transmitter: inhibits the clock, issues the start
// bit, shifts data/parity/stop on device clock falls and checks the device ACK.
module ps2_host_transmitter
  import ps2_host_transmitter_pkg::*;
#(
  parameter int INHIBIT_CYCLES = DEFAULT_INHIBIT_CYCLES,
  parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES,
  parameter int FILTER_LEN     = DEFAULT_FILTER_LEN
) (
  input  logic       Clock,
  input  logic       Reset,
  input  logic [7:0] iData,
  input  logic       iSend,
  input  logic       PS2_CLK_IN,
  input  logic       PS2_DATA_IN,
  output logic       oPS2_CLK_OE,
  output logic       oPS2_DATA_OE,
  output logic       oBusy,
  output logic       oDone,
  output logic       oError
);

  localparam int IW = $clog2(INHIBIT_CYCLES + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  state_t        state_q, state_d;
  logic [7:0]    data_q, data_d;
  logic          parity_q, parity_d;
  logic [IW-1:0] inh_cnt_q, inh_cnt_d;
  logic [TW-1:0] tmo_cnt_q, tmo_cnt_d;
  logic [3:0]    edge_cnt_q, edge_cnt_d;
  logic          data_oe_q, data_oe_d;
  logic          clk_prev_q, clk_prev_d;
  logic          done_q, done_d;
  logic          error_q, error_d;

  logic       clk_filt, data_filt;
  logic       clk_fall, timed_out;
  logic [3:0] edge_inc;
  logic [2:0] bit_idx;

  ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_clk_filter (
    .clk      (Clock),
    .rst      (Reset),
    .line_raw (PS2_CLK_IN),
    .line_filt(clk_filt)
  );

  ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_data_filter (
    .clk      (Clock),
    .rst      (Reset),
    .line_raw (PS2_DATA_IN),
    .line_filt(data_filt)
  );

  assign clk_fall  = clk_prev_q & ~clk_filt;
  assign timed_out = (tmo_cnt_q == TW'(TIMEOUT_CYCLES - 1));
  assign edge_inc  = (edge_cnt_q == ACK_EDGE) ? ACK_EDGE : edge_cnt_q + 4'd1;
  assign bit_idx   = 3'(edge_inc - 4'd1);

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state_q    <= IDLE;
      data_q     <= '0;
      parity_q   <= 1'b0;
      inh_cnt_q  <= '0;
      tmo_cnt_q  <= '0;
      edge_cnt_q <= '0;
      data_oe_q  <= 1'b0;
      clk_prev_q <= 1'b1;
      done_q     <= 1'b0;
      error_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      data_q     <= data_d;
      parity_q   <= parity_d;
      inh_cnt_q  <= inh_cnt_d;
      tmo_cnt_q  <= tmo_cnt_d;
      edge_cnt_q <= edge_cnt_d;
      data_oe_q  <= data_oe_d;
      clk_prev_q <= clk_prev_d;
      done_q     <= done_d;
      error_q    <= error_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    data_d     = data_q;
    parity_d   = parity_q;
    inh_cnt_d  = inh_cnt_q;
    tmo_cnt_d  = tmo_cnt_q;
    edge_cnt_d = edge_cnt_q;
    data_oe_d  = data_oe_q;
    clk_prev_d = clk_filt;
    done_d     = 1'b0;
    error_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (iSend) begin
          data_d     = iData;
          parity_d   = odd_parity(iData);
          inh_cnt_d  = '0;
          edge_cnt_d = '0;
          state_d    = INHIBIT;
        end
      end
      INHIBIT: begin
        if (inh_cnt_q == IW'(INHIBIT_CYCLES - 1)) begin
          state_d = START;
        end else begin
          inh_cnt_d = inh_cnt_q + IW'(1);
        end
      end
      START: begin
        tmo_cnt_d  = '0;
        edge_cnt_d = '0;
        data_oe_d  = 1'b1;
        state_d    = TX;
      end
      // Timeout has priority so a completion can never coincide with an abort
      TX: begin
        if (timed_out) begin
          error_d = 1'b1;
          state_d = IDLE;
        end else begin
          tmo_cnt_d = tmo_cnt_q + TW'(1);
          if (clk_fall) begin
            edge_cnt_d = edge_inc;
            if (edge_inc <= LAST_DATA_EDGE) begin
              data_oe_d = ~data_q[bit_idx];
            end else if (edge_inc == PARITY_EDGE) begin
              data_oe_d = ~parity_q;
            end else begin
              data_oe_d = 1'b0;
              state_d   = ACK_WAIT;
            end
          end
        end
      end
      ACK_WAIT: begin
        if (timed_out) begin
          error_d = 1'b1;
          state_d = IDLE;
        end else begin
          tmo_cnt_d = tmo_cnt_q + TW'(1);
          if (clk_fall) begin
            edge_cnt_d = edge_inc;
            if (!data_filt) begin
              state_d = RELEASE_WAIT;
            end else begin
              error_d = 1'b1;
              state_d = IDLE;
            end
          end
        end
      end
      RELEASE_WAIT: begin
        if (timed_out) begin
          error_d = 1'b1;
          state_d = IDLE;
        end else begin
          tmo_cnt_d = tmo_cnt_q + TW'(1);
          if (clk_filt && data_filt) begin
            done_d  = 1'b1;
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs decode from the state register, so reset releases both lines at once
  always_comb begin
    oPS2_CLK_OE  = (state_q == INHIBIT) || (state_q == START);
    oPS2_DATA_OE = 1'b0;
    if (state_q == START) begin
      oPS2_DATA_OE = 1'b1;
    end else if ((state_q == TX) || (state_q == ACK_WAIT)) begin
      oPS2_DATA_OE = data_oe_q;
    end
    oBusy  = (state_q != IDLE);
    oDone  = done_q;
    oError = error_q;
  end

endmodule

// File: tb/tb_ps2_host_transmitter.sv
// Self-checking bench: directed frame table, randomized commands against a frame
// model, and hand-written timeout, mid-transfer reset and held-request sequences.
module tb_ps2_host_transmitter;
  import ps2_host_transmitter_pkg::*;

  localparam int INH = 40;
  localparam int TMO = 3000;
  localparam int FLT = 8;
  localparam int H   = 25;

  typedef struct {
    logic [7:0] data;
    logic       ack;
    logic [9:0] exp_bits;
    logic       exp_done;
    logic       exp_err;
  } vec_t;

  logic       clock = 1'b0;
  logic       reset;
  logic [7:0] data_in;
  logic       send;
  logic       ps2_clk_in, ps2_data_in;
  logic       clk_oe, data_oe, busy, pulse_done, pulse_err;
  logic       dev_clk_low = 1'b0;
  logic       dev_data_low = 1'b0;
  logic       clk_glitch = 1'b0;
  logic       clk_bus, data_bus;

  int checks = 0;
  int errors = 0;
  int done_cnt = 0;
  int err_cnt = 0;

  assign clk_bus     = ~(clk_oe | dev_clk_low);
  assign data_bus    = ~(data_oe | dev_data_low);
  assign ps2_clk_in  = clk_bus & ~clk_glitch;
  assign ps2_data_in = data_bus;

  always #5 clock = ~clock;

  ps2_host_transmitter #(
    .INHIBIT_CYCLES(INH),
    .TIMEOUT_CYCLES(TMO),
    .FILTER_LEN    (FLT)
  ) dut (
    .Clock       (clock),
    .Reset       (reset),
    .iData       (data_in),
    .iSend       (send),
    .PS2_CLK_IN  (ps2_clk_in),
    .PS2_DATA_IN (ps2_data_in),
    .oPS2_CLK_OE (clk_oe),
    .oPS2_DATA_OE(data_oe),
    .oBusy       (busy),
    .oDone       (pulse_done),
    .oError      (pulse_err)
  );

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=0x%0h expected=0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Frame as the device should see it: 8 data bits LSB first, odd parity, stop
  function automatic logic [9:0] model_frame(input logic [7:0] d);
    int ones = 0;
    for (int i = 0; i < 8; i++) ones += int'(d[i]);
    return {1'b1, (ones % 2 == 0), d};
  endfunction

  always @(negedge clock) begin
    if (!reset && (pulse_done || pulse_err)) begin
      if (pulse_done) done_cnt++;
      if (pulse_err) err_cnt++;
      check_output("pulse_excl_busy_low", 32'({busy, pulse_done & pulse_err}), 32'd0);
    end
  end

  initial begin
    #3_000_000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  task automatic start_request(input logic [7:0] d, input logic hold);
    int n = 0;
    int guard = 0;
    @(negedge clock);
    data_in = d;
    send    = 1'b1;
    @(negedge clock);
    if (!hold) send = 1'b0;
    check_output("busy_after_send", 32'(busy), 32'd1);
    while (clk_oe && !data_oe && guard < INH + 100) begin
      n++;
      guard++;
      @(negedge clock);
    end
    check_output("inhibit_len", 32'(n), 32'(INH));
    check_output("start_oes", 32'({clk_oe, data_oe}), 32'b11);
    @(negedge clock);
    check_output("tx_start_bit", 32'({clk_oe, data_oe}), 32'b01);
  endtask

  task automatic device_clock(input logic ack, input logic glitch, input int stop_edge,
                              output logic [9:0] bits);
    int g = 0;
    bits = '0;
    while (!(clk_bus && !data_bus) && g < 500) begin
      g++;
      @(negedge clock);
    end
    check_output("start_bit_seen", 32'(clk_bus && !data_bus), 32'd1);
    for (int k = 1; k <= 10; k++) begin
      if (glitch && k == 3) begin
        repeat (H / 2) @(negedge clock);
        clk_glitch = 1'b1;
        @(negedge clock);
        clk_glitch = 1'b0;
        repeat (H - H / 2 - 1) @(negedge clock);
      end else begin
        repeat (H) @(negedge clock);
      end
      dev_clk_low = 1'b1;
      repeat (H) @(negedge clock);
      if (k == stop_edge) return;
      dev_clk_low = 1'b0;
      @(negedge clock);
      bits[k-1] = data_bus;
    end
    repeat (H) @(negedge clock);
    if (ack) dev_data_low = 1'b1;
    repeat (H) @(negedge clock);
    dev_clk_low = 1'b1;
    repeat (H) @(negedge clock);
    dev_clk_low = 1'b0;
    repeat (H) @(negedge clock);
    dev_data_low = 1'b0;
  endtask

  task automatic finish_transfer(input logic hold, input int done0, input int err0,
                                 input logic exp_done, input logic exp_err);
    int g = 0;
    int busy_seen = 0;
    while (busy && g < 400) begin
      g++;
      @(negedge clock);
    end
    if (hold) send = 1'b0;
    check_output("idle_reached", 32'(busy), 32'd0);
    repeat (30) begin
      @(negedge clock);
      if (busy) busy_seen++;
    end
    check_output("no_retrigger", 32'(busy_seen), 32'd0);
    check_output("done_pulses", 32'(done_cnt - done0), 32'(exp_done));
    check_output("error_pulses", 32'(err_cnt - err0), 32'(exp_err));
    check_output("lines_released", 32'({clk_oe, data_oe}), 32'd0);
  endtask

  task automatic apply_stimulus(input logic [7:0] d, input logic ack, input logic hold,
                                input logic glitch, input logic [9:0] exp_bits,
                                input logic exp_done, input logic exp_err);
    int done0 = done_cnt;
    int err0 = err_cnt;
    logic [9:0] bits;
    start_request(d, hold);
    device_clock(ack, glitch, 0, bits);
    check_output("frame_bits", 32'(bits), 32'(exp_bits));
    finish_transfer(hold, done0, err0, exp_done, exp_err);
  endtask

  initial begin
    vec_t tbl[5];
    logic [9:0] bits;
    logic [7:0] d;
    logic ack;
    int k;
    int done0, err0;

    tbl[0] = '{CMD_SET_LEDS, 1'b1, 10'h3ED, 1'b1, 1'b0};
    tbl[1] = '{CMD_ENABLE,   1'b1, 10'h2F4, 1'b1, 1'b0};
    tbl[2] = '{CMD_RESET,    1'b0, 10'h3FF, 1'b0, 1'b1};
    tbl[3] = '{8'h00,        1'b1, 10'h300, 1'b1, 1'b0};
    tbl[4] = '{CMD_ECHO,     1'b1, 10'h3EE, 1'b1, 1'b0};

    reset   = 1'b1;
    send    = 1'b0;
    data_in = 8'h00;
    repeat (3) @(negedge clock);
    check_output("reset_outputs", 32'({clk_oe, data_oe, busy, pulse_done, pulse_err}), 32'd0);
    reset = 1'b0;
    repeat (20) @(negedge clock);
    check_output("idle_outputs", 32'({clk_oe, data_oe, busy, pulse_done, pulse_err}), 32'd0);

    for (int i = 0; i < 5; i++) begin
      apply_stimulus(tbl[i].data, tbl[i].ack, 1'b0, 1'b0, tbl[i].exp_bits,
                     tbl[i].exp_done, tbl[i].exp_err);
    end

    for (int i = 0; i < 8; i++) begin
      d   = 8'($urandom_range(0, 255));
      ack = ($urandom_range(0, 3) != 0);
      apply_stimulus(d, ack, 1'b0, 1'b0, model_frame(d), ack, !ack);
    end

    // Request held high for the whole transfer, plus a one-cycle clock glitch
    apply_stimulus(8'h01, 1'b1, 1'b1, 1'b1, 10'h201, 1'b1, 1'b0);

    // Device never clocks: abort after the timeout window
    done0 = done_cnt;
    err0  = err_cnt;
    start_request(CMD_ENABLE, 1'b0);
    k = 0;
    while (!pulse_err && k < TMO + 200) begin
      @(negedge clock);
      k++;
    end
    check_output("timeout_cycles", 32'(k), 32'(TMO));
    check_output("timeout_release", 32'({clk_oe, data_oe, busy}), 32'd0);
    repeat (5) @(negedge clock);
    check_output("timeout_err_pulses", 32'(err_cnt - err0), 32'd1);
    check_output("timeout_done_pulses", 32'(done_cnt - done0), 32'd0);

    // Reset while the device holds the clock low at edge 5 of 0x01
    done0 = done_cnt;
    err0  = err_cnt;
    start_request(8'h01, 1'b0);
    device_clock(1'b1, 1'b0, 5, bits);
    check_output("pre_reset_oes", 32'({clk_oe, data_oe}), 32'b01);
    #2;
    reset = 1'b1;
    #1;
    check_output("reset_release_async", 32'({clk_oe, data_oe, busy}), 32'd0);
    @(negedge clock);
    dev_clk_low = 1'b0;
    repeat (3) @(negedge clock);
    reset = 1'b0;
    repeat (20) @(negedge clock);
    check_output("reset_no_done", 32'(done_cnt - done0), 32'd0);
    check_output("reset_no_error", 32'(err_cnt - err0), 32'd0);
    apply_stimulus(CMD_RESET, 1'b1, 1'b0, 1'b0, 10'h3FF, 1'b1, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
